// File: rtl/hcordic_pkg.sv
// hcordic_pkg: shared types and constants for the iterative hyperbolic CORDIC engine
//   state_t   FSM states IDLE/RUN/DONE
//   mode_t    ROT drives z to zero, VEC drives y to zero
//   atanh30   atanh(2^-i) for i = 1..TBL_MAX at 30 fractional bits, rounded down
//   is_repeat shift indices executed twice for hyperbolic convergence
//   KH_Q14    hyperbolic gain K_h for N >= 13, Q2.14
package hcordic_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {ROT, VEC} mode_t;
  localparam int TBL_MAX = 15;
  localparam int KH_Q14 = 13569;
  function automatic logic [31:0] atanh30(input int i);
    case (i)
      1:  return 32'd589812981;
      2:  return 32'd274247418;
      3:  return 32'd134923406;
      4:  return 32'd67196450;
      5:  return 32'd33565361;
      6:  return 32'd16778581;
      7:  return 32'd8388778;
      8:  return 32'd4194325;
      9:  return 32'd2097154;
      10: return 32'd1048576;
      11: return 32'd524288;
      12: return 32'd262144;
      13: return 32'd131072;
      14: return 32'd65536;
      15: return 32'd32768;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic is_repeat(input int i);
    return i == 4 || i == 13;
  endfunction
endpackage

// File: rtl/hcordic_atanh_rom.sv
// hcordic_atanh_rom: combinational atanh(2^-idx) lookup, Q2.(W-2)
//   idx  in  ITER_W  shift index
//   val  out W       angle constant, truncated from the 30-bit table
module hcordic_atanh_rom import hcordic_pkg::*; #(
  parameter int W = 16,
  parameter int ITER_W = 4
) (
  input  logic [ITER_W-1:0] idx,
  output logic [W-1:0]      val
);
  assign val = W'(atanh30(int'(idx)) >> (32 - W));
endmodule

// File: rtl/hcordic_iter.sv
// hcordic_iter: iterative hyperbolic CORDIC, one micro-rotation per clock
//   clk, reset                  clock, async active-high reset
//   in_valid/in_ready           operand handshake (accepted only in IDLE)
//   mode, n_iter                0 rotation / 1 vectoring, last shift index N
//   x_in, y_in, z_in, tag_in    signed Q2.(W-2) operands and sideband
//   out_valid/out_ready         result handshake
//   x_out, y_out, z_out, tag_out saturated results and tag
module hcordic_iter import hcordic_pkg::*; #(
  parameter int W = 16,
  parameter int GUARD = 2,
  parameter int MAX_ITER = 15,
  parameter int ITER_W = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [ITER_W-1:0] n_iter,
  input  logic [W-1:0]      x_in,
  input  logic [W-1:0]      y_in,
  input  logic [W-1:0]      z_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      x_out,
  output logic [W-1:0]      y_out,
  output logic [W-1:0]      z_out,
  output logic [TAG_W-1:0]  tag_out
);
  localparam int WD = W + GUARD;
  state_t state;
  mode_t md;
  logic [ITER_W-1:0] it, last, n_c;
  logic rep, dp, fin;
  logic [TAG_W-1:0] tag;
  logic [W-1:0] rom;
  logic signed [WD-1:0] x, y, z, xn, yn, zn, a;
  function automatic logic [W-1:0] sat(input logic signed [WD-1:0] v);
    return (&v[WD-1:W-1] || ~|v[WD-1:W-1]) ? v[W-1:0] : {v[WD-1], {(W-1){~v[WD-1]}}};
  endfunction
  hcordic_atanh_rom #(.W(W), .ITER_W(ITER_W)) u_rom (.idx(it), .val(rom));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign a = {{GUARD{1'b0}}, rom};
  always_comb begin
    dp = (md == ROT) ? ~z[WD-1] : y[WD-1];
    xn = dp ? x + (y >>> it) : x - (y >>> it);
    yn = dp ? y + (x >>> it) : y - (x >>> it);
    zn = dp ? z - a : z + a;
    // the last index is finished only once its repeat pass (if any) is done
    fin = (it == last) && (rep || !is_repeat(int'(it)));
    n_c = (n_iter == '0) ? ITER_W'(1) : (n_iter > ITER_W'(MAX_ITER)) ? ITER_W'(MAX_ITER) : n_iter;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      md <= ROT;
      it <= '0;
      last <= '0;
      rep <= 1'b0;
      tag <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
      tag_out <= '0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            x <= {{GUARD{x_in[W-1]}}, x_in};
            y <= {{GUARD{y_in[W-1]}}, y_in};
            z <= {{GUARD{z_in[W-1]}}, z_in};
            md <= mode_t'(mode);
            last <= n_c;
            tag <= tag_in;
            it <= ITER_W'(1);
            rep <= 1'b0;
            state <= RUN;
          end
        RUN: begin
          x <= xn;
          y <= yn;
          z <= zn;
          if (fin) begin
            x_out <= sat(xn);
            y_out <= sat(yn);
            z_out <= sat(zn);
            tag_out <= tag;
            state <= DONE;
          end else if (is_repeat(int'(it)) && !rep)
            rep <= 1'b1;
          else begin
            it <= it + ITER_W'(1);
            rep <= 1'b0;
          end
        end
        DONE:
          if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_hcordic_iter.sv
// tb_hcordic_iter: scoreboard bench for hcordic_iter (W=16, Q2.14)
module tb_hcordic_iter;
  logic clk = 0, reset = 1, in_valid = 0, mode = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [3:0] n_iter = 0, tag_in = 0, tag_out;
  logic [15:0] x_in = 0, y_in = 0, z_in = 0, x_out, y_out, z_out;
  typedef struct {int x; int y; int z; int tol; int lat; int tag;} exp_t;
  exp_t q[$];
  int pass_n = 0, total_n = 0;
  always #5 clk = ~clk;
  hcordic_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .n_iter(n_iter), .x_in(x_in), .y_in(y_in), .z_in(z_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
    .z_out(z_out), .tag_out(tag_out)
  );
  task automatic check(input string name, input int got, input int want, input int tol = 0);
    total_n++;
    if (got >= want - tol && got <= want + tol) pass_n++;
    else $display("FAIL %s: got %0d want %0d (+-%0d)", name, got, want, tol);
  endtask
  task automatic cmp_out(input exp_t e, input string p);
    check({p, "_x"}, int'($signed(x_out)), e.x, e.tol);
    check({p, "_y"}, int'($signed(y_out)), e.y, e.tol);
    check({p, "_z"}, int'($signed(z_out)), e.z, e.tol);
    check({p, "_tag"}, int'(tag_out), e.tag);
  endtask
  task automatic drive(input logic m, input int n, input int xi, input int yi, input int zi, input int tg);
    in_valid = 1;
    mode = m;
    n_iter = n[3:0];
    x_in = xi[15:0];
    y_in = yi[15:0];
    z_in = zi[15:0];
    tag_in = tg[3:0];
  endtask
  task automatic op(input logic m, input int n, input int xi, input int yi, input int zi,
                    input int tg, input int ex, input int ey, input int ez, input int tol,
                    input int hold);
    exp_t e;
    int lat, ne;
    ne = (n == 0) ? 1 : n;
    ne = ne + int'(ne >= 4) + int'(ne >= 13);
    e.x = ex; e.y = ey; e.z = ez; e.tol = tol; e.lat = ne; e.tag = tg;
    q.push_back(e);
    @(negedge clk);
    check("in_ready_idle", int'(in_ready), 1);
    drive(m, n, xi, yi, zi, tg);
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("out_valid", int'(out_valid), 1);
    e = q.pop_front();
    check("latency", lat, e.lat);
    cmp_out(e, "res");
    for (int k = 0; k < hold; k++) begin
      drive(~m, 5, int'($urandom_range(0, 65535)), 100, 200, 15);
      @(posedge clk);
      #1;
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_valid", int'(out_valid), 1);
    end
    in_valid = 0;
    if (hold > 0) cmp_out(e, "held");
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("drained_valid", int'(out_valid), 0);
    check("drained_ready", int'(in_ready), 1);
  endtask
  initial begin
    #12;
    check("rst_ready", int'(in_ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_z", int'(z_out), 0);
    check("rst_tag", int'(tag_out), 0);
    @(negedge clk) reset = 0;
    op(0, 14, 19784, 0, 8192, 1, 18475, 8538, 0, 6, 0);
    op(1, 14, 16384, 8192, 0, 2, 11751, 0, 8999, 6, 0);
    op(0, 3, 19784, 0, 8192, 3, 17929, 7109, 1319, 0, 0);
    op(0, 0, 16384, 0, 4096, 4, 16384, 8192, -4903, 0, 0);
    op(0, 14, 19784, 0, 8192, 5, 18475, 8538, 0, 6, 10);
    @(negedge clk);
    drive(1, 14, 16384, 8192, 0, 9);
    @(posedge clk);
    #1 in_valid = 0;
    repeat (5) @(posedge clk);
    #2 reset = 1;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_ready", int'(in_ready), 1);
    @(negedge clk) reset = 0;
    op(1, 14, 16384, 8192, 0, 6, 11751, 0, 8999, 6, 0);
    op(0, 14, 32767, 32767, 8192, 7, 32767, 32767, 0, 0, 0);
    op(0, 14, -32768, -32768, 8192, 8, -32768, -32768, 0, 0, 0);
    check("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
